// File: rtl/lab2_proc_imul_issue_ctrl.sv
// Issue/retire control for the shared iterative multiplier beside the X stage.
// Issues a multiply as it leaves D, stalls X until the product returns, then holds the product.
module lab2_proc_imul_issue_ctrl #(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mul_D,
  input  logic                   squash_D,
  input  logic                   ostall_D_other,
  input  logic                   go_X,
  input  logic [p_nbits-1:0]     op1_D,
  input  logic [p_nbits-1:0]     op2_D,
  output logic                   imul_req_val,
  input  logic                   imul_req_rdy,
  output logic [2*p_nbits-1:0]   imul_req_msg,
  input  logic                   imul_resp_val,
  output logic                   imul_resp_rdy,
  input  logic [p_nbits-1:0]     imul_resp_msg,
  output logic                   ostall_D_imul,
  output logic                   ostall_X_imul,
  output logic [p_nbits-1:0]     imul_result_X,
  output logic                   imul_result_val_X,
  output logic [31:0]            imul_stall_cycles
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [p_nbits-1:0] result_q, result_d;
  logic [31:0]        cnt_q;
  logic               issue;

  // DONE can issue only in the cycle the held multiply leaves X
  assign imul_req_val  = mul_D & ~squash_D & ~ostall_D_other &
                         ((state_q == IDLE) | ((state_q == DONE) & go_X));
  assign issue         = imul_req_val & imul_req_rdy;
  assign imul_req_msg  = {op1_D, op2_D};
  assign ostall_D_imul = mul_D & ~squash_D & ~issue;

  assign ostall_X_imul     = (state_q == BUSY);
  assign imul_resp_rdy     = (state_q == BUSY);
  assign imul_result_X     = result_q;
  assign imul_result_val_X = (state_q == DONE);
  assign imul_stall_cycles = cnt_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (issue) state_d = BUSY;
      BUSY: if (imul_resp_val) begin
        state_d  = DONE;
        result_d = imul_resp_msg;
      end
      DONE: if (go_X) state_d = issue ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (ostall_X_imul) cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_lab2_proc_imul_issue_ctrl.sv
// Directed bench for lab2_proc_imul_issue_ctrl; one task per scenario.
module tb_lab2_proc_imul_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset, mul_D, squash_D, ostall_D_other, go_X;
  logic [31:0] op1_D, op2_D;
  logic        imul_req_val, imul_req_rdy;
  logic [63:0] imul_req_msg;
  logic        imul_resp_val, imul_resp_rdy;
  logic [31:0] imul_resp_msg;
  logic        ostall_D_imul, ostall_X_imul;
  logic [31:0] imul_result_X;
  logic        imul_result_val_X;
  logic [31:0] imul_stall_cycles;

  int errors = 0;
  int checks = 0;

  lab2_proc_imul_issue_ctrl #(.p_nbits(32)) dut (
    .clk(clk), .reset(reset), .mul_D(mul_D), .squash_D(squash_D),
    .ostall_D_other(ostall_D_other), .go_X(go_X), .op1_D(op1_D), .op2_D(op2_D),
    .imul_req_val(imul_req_val), .imul_req_rdy(imul_req_rdy), .imul_req_msg(imul_req_msg),
    .imul_resp_val(imul_resp_val), .imul_resp_rdy(imul_resp_rdy), .imul_resp_msg(imul_resp_msg),
    .ostall_D_imul(ostall_D_imul), .ostall_X_imul(ostall_X_imul),
    .imul_result_X(imul_result_X), .imul_result_val_X(imul_result_val_X),
    .imul_stall_cycles(imul_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    mul_D = 0; squash_D = 0; ostall_D_other = 0; go_X = 0; op1_D = 0; op2_D = 0;
    imul_req_rdy = 0; imul_resp_val = 0; imul_resp_msg = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); reset = 1;
    step(); step();
    reset = 0; #1;
    checks++; if (imul_result_X !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", imul_result_X); end
    checks++; if (imul_result_val_X !== 1'b0) begin errors++; $display("FAIL reset_val got %b exp 0", imul_result_val_X); end
    checks++; if (imul_stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", imul_stall_cycles); end
    checks++; if (ostall_X_imul !== 1'b0 || imul_resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_xstall got %b/%b exp 0/0", ostall_X_imul, imul_resp_rdy); end
    checks++; if (imul_req_val !== 1'b0 || ostall_D_imul !== 1'b0) begin errors++; $display("FAIL reset_req got %b/%b exp 0/0", imul_req_val, ostall_D_imul); end
    step();
  endtask

  task automatic test_single();
    mul_D = 1; op1_D = 32'd3; op2_D = 32'd5; imul_req_rdy = 1; #1;
    checks++; if (imul_req_val !== 1'b1 || ostall_D_imul !== 1'b0) begin errors++; $display("FAIL single_issue got %b/%b exp 1/0", imul_req_val, ostall_D_imul); end
    checks++; if (imul_req_msg !== 64'h00000003_00000005) begin errors++; $display("FAIL single_msg got %h exp 0000000300000005", imul_req_msg); end
    step();
    mul_D = 0; imul_req_rdy = 0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin imul_resp_val = 1; imul_resp_msg = 32'd15; end
      #1;
      checks++; if (ostall_X_imul !== 1'b1 || imul_resp_rdy !== 1'b1) begin errors++; $display("FAIL single_busy%0d got %b/%b exp 1/1", i, ostall_X_imul, imul_resp_rdy); end
      step();
    end
    imul_resp_val = 0; imul_resp_msg = 0; #1;
    checks++; if (imul_result_X !== 32'd15 || imul_result_val_X !== 1'b1) begin errors++; $display("FAIL single_result got %h/%b exp f/1", imul_result_X, imul_result_val_X); end
    checks++; if (imul_stall_cycles !== 32'd4) begin errors++; $display("FAIL single_cnt got %0d exp 4", imul_stall_cycles); end
    checks++; if (ostall_X_imul !== 1'b0) begin errors++; $display("FAIL single_xfree got %b exp 0", ostall_X_imul); end
  endtask

  task automatic test_back_to_back();
    go_X = 1; mul_D = 1; op1_D = 32'd7; op2_D = 32'hFFFFFFFE; imul_req_rdy = 1; #1;
    checks++; if (imul_req_val !== 1'b1 || ostall_D_imul !== 1'b0) begin errors++; $display("FAIL b2b_issue got %b/%b exp 1/0", imul_req_val, ostall_D_imul); end
    checks++; if (imul_req_msg !== 64'h00000007_FFFFFFFE) begin errors++; $display("FAIL b2b_msg got %h exp 00000007fffffffe", imul_req_msg); end
    checks++; if (imul_result_X !== 32'd15 || imul_result_val_X !== 1'b1) begin errors++; $display("FAIL b2b_oldres got %h/%b exp f/1", imul_result_X, imul_result_val_X); end
    step();
    go_X = 0; mul_D = 0; imul_req_rdy = 0; #1;
    checks++; if (ostall_X_imul !== 1'b1 || imul_result_val_X !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b/%b exp 1/0", ostall_X_imul, imul_result_val_X); end
    step();
    imul_resp_val = 1; imul_resp_msg = 32'hFFFFFFF2;
    step();
    imul_resp_val = 0; imul_resp_msg = 0; #1;
    checks++; if (imul_result_X !== 32'hFFFFFFF2 || imul_result_val_X !== 1'b1) begin errors++; $display("FAIL b2b_result got %h/%b exp fffffff2/1", imul_result_X, imul_result_val_X); end
    checks++; if (imul_stall_cycles !== 32'd6) begin errors++; $display("FAIL b2b_cnt got %0d exp 6", imul_stall_cycles); end
  endtask

  task automatic test_downstream_stall();
    go_X = 1; mul_D = 1; op1_D = 32'd1; op2_D = 32'd2; imul_req_rdy = 1;
    step();
    go_X = 0; mul_D = 0; imul_req_rdy = 0; imul_resp_val = 1; imul_resp_msg = 32'hDEADBEEF;
    step();
    imul_resp_val = 0; imul_resp_msg = 0;
    mul_D = 1; imul_req_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      // spurious response while DONE must be ignored
      if (i == 1) begin imul_resp_val = 1; imul_resp_msg = 32'h12345678; end
      else begin imul_resp_val = 0; imul_resp_msg = 0; end
      #1;
      checks++; if (imul_req_val !== 1'b0 || ostall_D_imul !== 1'b1) begin errors++; $display("FAIL dstall_hold%0d got %b/%b exp 0/1", i, imul_req_val, ostall_D_imul); end
      checks++; if (imul_result_X !== 32'hDEADBEEF || imul_result_val_X !== 1'b1 || imul_resp_rdy !== 1'b0) begin errors++; $display("FAIL dstall_res%0d got %h/%b/%b exp deadbeef/1/0", i, imul_result_X, imul_result_val_X, imul_resp_rdy); end
      step();
    end
    imul_resp_val = 0; imul_resp_msg = 0;
    go_X = 1; imul_req_rdy = 0; #1;
    checks++; if (imul_req_val !== 1'b1 || ostall_D_imul !== 1'b1) begin errors++; $display("FAIL dstall_norrdy got %b/%b exp 1/1", imul_req_val, ostall_D_imul); end
    step();
    go_X = 0; mul_D = 0; #1;
    checks++; if (imul_result_val_X !== 1'b0 || ostall_X_imul !== 1'b0) begin errors++; $display("FAIL dstall_idle got %b/%b exp 0/0", imul_result_val_X, ostall_X_imul); end
    checks++; if (imul_stall_cycles !== 32'd7) begin errors++; $display("FAIL dstall_cnt got %0d exp 7", imul_stall_cycles); end
  endtask

  task automatic test_mul_busy();
    mul_D = 1; op1_D = 32'd9; op2_D = 32'd9; imul_req_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ostall_D_imul !== 1'b1 || imul_req_val !== 1'b1) begin errors++; $display("FAIL mbusy_d%0d got %b/%b exp 1/1", i, ostall_D_imul, imul_req_val); end
      step();
      checks++; if (ostall_X_imul !== 1'b0 || imul_result_val_X !== 1'b0) begin errors++; $display("FAIL mbusy_idle%0d got %b/%b exp 0/0", i, ostall_X_imul, imul_result_val_X); end
    end
    ostall_D_other = 1; imul_req_rdy = 1; #1;
    checks++; if (imul_req_val !== 1'b0 || ostall_D_imul !== 1'b1) begin errors++; $display("FAIL mbusy_other got %b/%b exp 0/1", imul_req_val, ostall_D_imul); end
    step();
    ostall_D_other = 0; mul_D = 0; imul_req_rdy = 0; #1;
    checks++; if (ostall_X_imul !== 1'b0 || imul_stall_cycles !== 32'd7) begin errors++; $display("FAIL mbusy_cnt got %b/%0d exp 0/7", ostall_X_imul, imul_stall_cycles); end
  endtask

  task automatic test_squash_reset();
    mul_D = 1; squash_D = 1; imul_req_rdy = 1; #1;
    checks++; if (imul_req_val !== 1'b0 || ostall_D_imul !== 1'b0) begin errors++; $display("FAIL squash got %b/%b exp 0/0", imul_req_val, ostall_D_imul); end
    step();
    checks++; if (ostall_X_imul !== 1'b0) begin errors++; $display("FAIL squash_noissue got %b exp 0", ostall_X_imul); end
    squash_D = 0;
    step();
    mul_D = 0; imul_req_rdy = 0; #1;
    checks++; if (ostall_X_imul !== 1'b1) begin errors++; $display("FAIL sreset_busy got %b exp 1", ostall_X_imul); end
    reset = 1;
    step();
    reset = 0; imul_resp_val = 1; imul_resp_msg = 32'd123; #1;
    checks++; if (imul_resp_rdy !== 1'b0 || ostall_X_imul !== 1'b0) begin errors++; $display("FAIL sreset_rdy got %b/%b exp 0/0", imul_resp_rdy, ostall_X_imul); end
    step();
    imul_resp_val = 0; imul_resp_msg = 0; #1;
    checks++; if (imul_result_val_X !== 1'b0 || imul_result_X !== 32'd0) begin errors++; $display("FAIL sreset_state got %b/%h exp 0/0", imul_result_val_X, imul_result_X); end
    checks++; if (imul_stall_cycles !== 32'd0) begin errors++; $display("FAIL sreset_cnt got %0d exp 0", imul_stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_downstream_stall();
    test_mul_busy();
    test_squash_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lab2_proc_imul_issue_ctrl.md
# lab2_proc_imul_issue_ctrl

Issue/retire controller that shares the iterative integer multiplier with the 5-stage pipeline. It issues a multiply request when a `mul` leaves D and holds X stalled until the product returns. The product is captured in a holding register and presented to the X-stage result mux until X advances. It sits beside the X-stage datapath and exchanges val/rdy handshakes with the multiplier and stall/go signals with pipeline control.

## Interface

Parameters:
- `p_nbits`, 32, operand/result width

Ports:
- `clk`  in  1  clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `mul_D`  in  1  valid `mul` instruction in D
- `squash_D`  in  1  D instruction squashed this cycle
- `ostall_D_other`  in  1  D stalled for non-multiply reasons (RAW, fetch)
- `go_X`  in  1  X stage advancing to M this cycle
- `op1_D`, `op2_D`  in  p_nbits  multiplicand / multiplier from D operand muxes
- `imul_req_val`  out  1  request valid to multiplier
- `imul_req_rdy`  in  1  multiplier ready
- `imul_req_msg`  out  2*p_nbits  `{op1_D, op2_D}`
- `imul_resp_val`  in  1  product valid
- `imul_resp_rdy`  out  1  controller accepts product
- `imul_resp_msg`  in  p_nbits  product (low p_nbits)
- `ostall_D_imul`  out  1  D must stall, multiply cannot issue
- `ostall_X_imul`  out  1  X must stall, product not yet present
- `imul_result_X`  out  p_nbits  held product for the ex_result mux
- `imul_result_val_X`  out  1  held product valid
- `imul_stall_cycles`  out  32  count of cycles with `ostall_X_imul`=1

## Operation

State machine states:
- IDLE: no multiply in X.
- BUSY: request accepted, product outstanding.
- DONE: product held, multiply in X waiting to advance.

Issue condition: `issue = imul_req_val & imul_req_rdy`.
- `imul_req_val = mul_D & ~squash_D & ~ostall_D_other & (IDLE | (DONE & go_X))`.
- `imul_req_msg` is driven combinationally from `op1_D`/`op2_D`.

D stall: `ostall_D_imul = mul_D & ~squash_D & ~issue`. It is forced low whenever `squash_D` is high.

X stall and response side:
- `ostall_X_imul = (state==BUSY)`.
- `imul_resp_rdy = (state==BUSY)`.

Transitions:
- IDLE: `issue` → BUSY; otherwise stay.
- BUSY: `imul_resp_val` → DONE, and `imul_resp_msg` is loaded into the holding register. Otherwise stay. `go_X` is ignored in this state.
- DONE: `go_X & issue` → BUSY. `go_X & ~issue` → IDLE. `~go_X` → stay; the holding register is unchanged and no issue occurs.

Outputs:
- `imul_result_X` = holding register.
- `imul_result_val_X = (state==DONE)`.
- In the DONE→BUSY cycle, the old product is still presented.

Counter:
- `imul_stall_cycles` increments by 1 on every cycle with `ostall_X_imul`=1.
- Wraps modulo 2^32.

Arithmetic: the product is the low p_nbits of the unsigned/two's-complement product. This block passes it through unmodified and performs no truncation of its own.

Boundary conditions:
- `imul_resp_val` in IDLE or DONE: not accepted (`imul_resp_rdy`=0) and does not change state.
- `squash_D` with `mul_D`: no request, no stall.
- Simultaneous `go_X`, `mul_D` and `~imul_req_rdy` in DONE: go to IDLE, and `ostall_D_imul`=1.
- Reset mid-operation: state → IDLE, holding register → 0, counter → 0. Any outstanding product is discarded; the multiplier is reset by the same `reset`.

## Timing

- Reset values: state IDLE; all outputs 0 except `imul_req_msg` and `ostall_D_imul`, which are combinational from inputs. `imul_req_val`=0 while `mul_D`=0.
- Issue at cycle t puts the multiply in X at t+1, in BUSY.
- If the response arrives at cycle t+k (k≥1), the state is DONE at t+k+1. `ostall_X_imul`=1 for cycles t+1..t+k, i.e. k cycles, so the counter advances by k.
- Minimum X occupancy is 2 cycles.
- Back-to-back multiplies: issue in the DONE+`go_X` cycle, with no bubble beyond the BUSY latency.
- All state updates occur on the rising edge of `clk`.
- No combinational path from `imul_resp_val` to `ostall_X_imul`.

## Test plan

- Reset asserted 2 cycles, then released with all inputs 0 → state IDLE, `imul_result_X`=0, `imul_result_val_X`=0, `imul_stall_cycles`=0.
- Single multiply, 3×5: `mul_D`=1 with `imul_req_rdy`=1 at t, `imul_resp_msg`=15 valid at t+4 → `ostall_X_imul`=1 for t+1..t+4. At t+5, `imul_result_X`=15 and `imul_result_val_X`=1; counter=4.
- Multiplier busy: `mul_D`=1 with `imul_req_rdy`=0 for 3 cycles → `ostall_D_imul`=1 each cycle, no request handshake, state IDLE.
- Back-to-back: DONE holding 15, `go_X`=1, `mul_D`=1, ops 7 and −2, `imul_req_rdy`=1 → issue that cycle with msg `{7, 0xFFFFFFFE}` and `imul_result_X`=15. Next cycle BUSY; the product 0xFFFFFFF2 is later held.
- Downstream stall: DONE holding 0xDEADBEEF, `go_X`=0 for 3 cycles, `mul_D`=1 → no issue, `ostall_D_imul`=1, result stable. Then `go_X`=1 with `imul_req_rdy`=0 → IDLE.
- Squash and reset: `mul_D`=1 with `squash_D`=1 → `imul_req_val`=0 and `ostall_D_imul`=0. Reset asserted in BUSY, then a spurious `imul_resp_val` the next cycle → state IDLE, response not accepted, counter=0.
